dmem_result_checker: RTL and testbench

//  Hardware self-check sequencer for the mips_32 single-cycle core: holds the core in reset,

---
 rtl/dmem_result_checker.sv | 164 ++++++++++++++++
 tb/tb_dmem_result_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_result_checker.sv
// Self-check sequencer for the mips_32 core: resets the core, lets it run for a
// fixed window, freezes it, then walks data memory comparing each word against
// an expected-value ROM and keeps pass/fail counts plus a weighted score.
module dmem_result_checker #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 134,
  parameter int FIRST_ADDR = 11,
  parameter int LAST_ADDR  = 65,
  parameter int SPLIT_ADDR = 56
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [7:0]        pass_cnt,
  output logic [7:0]        fail_cnt,
  output logic [9:0]        points_x2,
  output logic [ADDR_W-1:0] first_fail
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_RUN    = 3'd2,
    S_ADDR   = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [15:0]       RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0]       RUN_LAST  = 16'(RUN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_SPLIT = ADDR_W'(SPLIT_ADDR);

  state_t              state_reg;
  logic [15:0]         cyc_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                cpu_reset_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [7:0]          pass_reg;
  logic [7:0]          fail_reg;
  logic [9:0]          points_reg;
  logic [ADDR_W-1:0]   first_fail_reg;

  logic                word_ok;
  logic [9:0]          weight;
  logic [10:0]         points_sum;
  logic [9:0]          points_next;

  // Compare result and saturating score increment for the word being sampled
  always_comb begin
    word_ok     = (mem_rd_data == exp_data);
    weight      = (addr_reg >= ADDR_SPLIT) ? 10'd5 : 10'd2;
    points_sum  = {1'b0, points_reg} + {1'b0, weight};
    points_next = points_sum[10] ? 10'h3ff : points_sum[9:0];
  end

  // Sequencer: reset window, run window, then two cycles per scanned word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cyc_reg        <= '0;
      addr_reg       <= ADDR_FIRST;
      cpu_reset_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pass_reg       <= '0;
      fail_reg       <= '0;
      points_reg     <= '0;
      first_fail_reg <= '1;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg      <= S_RST;
            cyc_reg        <= '0;
            addr_reg       <= ADDR_FIRST;
            cpu_reset_reg  <= 1'b1;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            pass_reg       <= '0;
            fail_reg       <= '0;
            points_reg     <= '0;
            first_fail_reg <= '1;
          end
        end
        S_RST: begin
          if (cyc_reg == RST_LAST) begin
            state_reg     <= S_RUN;
            cyc_reg       <= '0;
            cpu_reset_reg <= 1'b0;
          end else begin
            cyc_reg <= cyc_reg + 16'd1;
          end
        end
        S_RUN: begin
          if (cyc_reg == RUN_LAST) begin
            // Core goes back into reset so it cannot store while we scan
            state_reg     <= S_ADDR;
            cyc_reg       <= '0;
            addr_reg      <= ADDR_FIRST;
            cpu_reset_reg <= 1'b1;
          end else begin
            cyc_reg <= cyc_reg + 16'd1;
          end
        end
        S_ADDR: begin
          // Address already on the bus; a sync-read memory returns data next cycle
          state_reg <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (word_ok) begin
            if (pass_reg != 8'hff) pass_reg <= pass_reg + 8'd1;
            points_reg <= points_next;
          end else begin
            if (fail_reg != 8'hff) fail_reg <= fail_reg + 8'd1;
            if (first_fail_reg == '1) first_fail_reg <= addr_reg;
          end
          if (addr_reg == ADDR_LAST) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= S_ADDR;
            addr_reg  <= addr_reg + ADDR_W'(1);
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          cpu_reset_reg <= 1'b1;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Mismatch flags the failing compare in the same cycle the word is sampled
  always_comb begin
    mismatch = (state_reg == S_SAMPLE) && !word_ok;
  end

  assign cpu_reset  = cpu_reset_reg;
  assign mem_addr   = addr_reg;
  assign exp_addr   = addr_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign pass_cnt   = pass_reg;
  assign fail_cnt   = fail_reg;
  assign points_x2  = points_reg;
  assign first_fail = first_fail_reg;

endmodule

// File: tb/tb_dmem_result_checker.sv
// Bench for dmem_result_checker: a memory/ROM model around the checker, a table
// of directed scenarios, random corruption checked against a word-list model,
// and hand sequences for mid-scan reset and reset/start collision.
module tb_dmem_result_checker;

  localparam int FIRST = 11;
  localparam int LAST  = 65;
  localparam int SPLIT = 56;
  localparam int NWORD = LAST - FIRST + 1;
  localparam int LATENCY = 1 + 5 + 134 + 2 * NWORD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cpu_reset;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic [7:0]  exp_addr;
  logic [31:0] exp_data;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [7:0]  pass_cnt;
  logic [7:0]  fail_cnt;
  logic [9:0]  points_x2;
  logic [7:0]  first_fail;

  logic [31:0] mem     [256];
  logic [31:0] exp_rom [256];
  logic [31:0] sync_q;
  bit          sync_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  int mdl_pass, mdl_fail, mdl_pts, mdl_first;
  int exp_mm_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) sync_q <= mem[mem_addr];
  assign mem_rd_data = sync_mode ? sync_q : mem[mem_addr];
  assign exp_data    = exp_rom[exp_addr];

  dmem_result_checker dut (
    .clk(clk), .reset(reset), .start(start), .cpu_reset(cpu_reset),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .exp_addr(exp_addr),
    .exp_data(exp_data), .busy(busy), .done(done), .mismatch(mismatch),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .points_x2(points_x2),
    .first_fail(first_fail)
  );

  typedef struct {
    string name;
    int    ca;      // corrupted address or -1
    int    cb;      // second corrupted address or -1
    bit    sync;
    bit    pulse;   // pulse start during RUN
    int    e_pass;
    int    e_fail;
    int    e_pts;
    int    e_first;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void restore_mem();
    for (int a = 0; a < 256; a++) mem[a] = exp_rom[a];
  endfunction

  // Reference: score each checked word directly from memory vs ROM
  function automatic void model();
    mdl_pass = 0; mdl_fail = 0; mdl_pts = 0; mdl_first = 255;
    exp_mm_q.delete();
    for (int a = FIRST; a <= LAST; a++) begin
      if (mem[a] == exp_rom[a]) begin
        mdl_pass++;
        mdl_pts += (a >= SPLIT) ? 5 : 2;
      end else begin
        mdl_fail++;
        exp_mm_q.push_back(a);
        if (mdl_first == 255) mdl_first = a;
      end
    end
  endfunction

  task automatic run_scn(input string name, input bit pulse_in_run,
                         input int e_pass, input int e_fail, input int e_pts,
                         input int e_first);
    int cyc, phase, rst_hi, run_lo, post_hi, glitch, busy_bad, addr_bad;
    int mm_q[$];
    int hold_pass;
    cyc = 0; phase = 0; rst_hi = 0; run_lo = 0; post_hi = 0;
    glitch = 0; busy_bad = 0; addr_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, ".clear"}, {pass_cnt, fail_cnt, first_fail}, {8'd0, 8'd0, 8'hff});
    chk({name, ".clear_pts"}, int'(points_x2), 0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 1000) begin
      if (cpu_reset) begin
        if (phase == 0) rst_hi++;
        else begin phase = 2; post_hi++; end
      end else begin
        if (phase == 0) phase = 1;
        if (phase == 1) run_lo++;
        else glitch++;
      end
      if (!busy) busy_bad++;
      if (exp_addr !== mem_addr) addr_bad++;
      if (mismatch) mm_q.push_back(int'(mem_addr));
      start = (pulse_in_run && cyc == 60);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, ".latency"}, cyc, LATENCY);
    chk({name, ".rst_hi"}, rst_hi, 5);
    chk({name, ".run_lo"}, run_lo, 134);
    chk({name, ".post_hi"}, post_hi, 2 * NWORD);
    chk({name, ".cpu_glitch"}, glitch, 0);
    chk({name, ".busy_low"}, busy_bad, 0);
    chk({name, ".exp_addr"}, addr_bad, 0);
    chk({name, ".pass_cnt"}, int'(pass_cnt), e_pass);
    chk({name, ".fail_cnt"}, int'(fail_cnt), e_fail);
    chk({name, ".points_x2"}, int'(points_x2), e_pts);
    chk({name, ".first_fail"}, int'(first_fail), e_first);
    chk({name, ".mm_count"}, mm_q.size(), exp_mm_q.size());
    for (int i = 0; i < mm_q.size() && i < exp_mm_q.size(); i++)
      chk({name, ".mm_addr"}, mm_q[i], exp_mm_q[i]);
    hold_pass = int'(pass_cnt);
    repeat (3) @(negedge clk);
    chk({name, ".done_hold"}, {done, busy, cpu_reset}, {1'b1, 1'b0, 1'b1});
    chk({name, ".cnt_frozen"}, int'(pass_cnt), hold_pass);
    $display("scenario %s: cycles=%0d pass=%0d fail=%0d points_x2=%0d first_fail=%0d mm=%0d",
             name, cyc, pass_cnt, fail_cnt, points_x2, first_fail, mm_q.size());
  endtask

  initial begin
    tbl[0] = '{"clean",       -1, -1, 1'b0, 1'b0, 55, 0, 140, 255};
    tbl[1] = '{"bad13_60",    13, 60, 1'b0, 1'b0, 53, 2, 133, 13};
    tbl[2] = '{"start_in_run",-1, -1, 1'b0, 1'b1, 55, 0, 140, 255};
    tbl[3] = '{"sync_clean",  -1, -1, 1'b1, 1'b0, 55, 0, 140, 255};
    tbl[4] = '{"sync_bad",    13, 60, 1'b1, 1'b0, 53, 2, 133, 13};
    tbl[5] = '{"edges_11_65", 11, 65, 1'b0, 1'b0, 53, 2, 133, 11};
    tbl[6] = '{"split_55_56", 55, 56, 1'b1, 1'b0, 53, 2, 133, 55};

    for (int a = 0; a < 256; a++) exp_rom[a] = $urandom;
    restore_mem();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.flags", {busy, done, cpu_reset, mismatch}, {1'b0, 1'b0, 1'b1, 1'b0});
    chk("rst.addr", {mem_addr, exp_addr}, {8'd11, 8'd11});
    chk("rst.cnts", {pass_cnt, fail_cnt, first_fail}, {8'd0, 8'd0, 8'hff});
    chk("rst.pts", int'(points_x2), 0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      restore_mem();
      if (tbl[i].ca >= 0) mem[tbl[i].ca] = ~exp_rom[tbl[i].ca];
      if (tbl[i].cb >= 0) mem[tbl[i].cb] = exp_rom[tbl[i].cb] ^ 32'h8000_0000;
      sync_mode = tbl[i].sync;
      exp_mm_q.delete();
      if (tbl[i].ca >= 0) exp_mm_q.push_back(tbl[i].ca);
      if (tbl[i].cb >= 0) exp_mm_q.push_back(tbl[i].cb);
      run_scn(tbl[i].name, tbl[i].pulse, tbl[i].e_pass, tbl[i].e_fail,
              tbl[i].e_pts, tbl[i].e_first);
    end

    // Random corruption against the model
    for (int r = 0; r < 4; r++) begin
      restore_mem();
      for (int a = 0; a < 256; a++)
        if ($urandom_range(7, 0) == 0) mem[a] = exp_rom[a] ^ (32'h1 << $urandom_range(31, 0));
      sync_mode = $urandom_range(1, 0) == 1;
      model();
      run_scn($sformatf("rand%0d", r), $urandom_range(1, 0) == 1,
              mdl_pass, mdl_fail, mdl_pts, mdl_first);
    end

    // Reset during SAMPLE of address 30
    begin
      int guard;
      restore_mem();
      mem[13] = ~exp_rom[13];
      sync_mode = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      guard = 0;
      while (mem_addr !== 8'd30 && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      chk("abort.reach30", int'(guard < 1000), 1);
      @(negedge clk);              // SAMPLE cycle of address 30
      chk("abort.pre_fail", int'(fail_cnt), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort.flags", {busy, done, cpu_reset, mismatch}, {1'b0, 1'b0, 1'b1, 1'b0});
      chk("abort.cnts", {pass_cnt, fail_cnt, first_fail, mem_addr}, {8'd0, 8'd0, 8'hff, 8'd11});
      chk("abort.pts", int'(points_x2), 0);
      $display("scenario abort30: busy=%0d cpu_reset=%0d pass=%0d fail=%0d", busy, cpu_reset,
               pass_cnt, fail_cnt);
    end

    // Reset and start together: reset wins, checker stays idle
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    chk("rst_start.idle", {busy, done, cpu_reset}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("rst_start.still_idle", int'(busy), 0);
    $display("scenario reset_with_start: busy=%0d", busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
